// File: rtl/wb_arb_pkg.sv
// Package shared by the writeback-port arbiter and its result FIFO.
// Holds the datapath widths, the writeback request record and the grant
// selector type used by the top level.
package wb_arb_pkg;

    localparam int XLEN       = 32;  // WriteData / source data width
    localparam int REG_ADDR_W = 5;   // 32 architectural registers

    // One register-file write: destination index plus data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Which source owns the write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MUL  = 2'd2
    } grant_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t used to buffer mul/div results while the
// ALU holds the register-file write port.
// Ports:
//   clk, rst  clock, synchronous active-high reset (empties the FIFO)
//   push      enqueue wdata (ignored when full)
//   wdata     entry to enqueue
//   pop       dequeue head (ignored when empty)
//   full      all DEPTH entries occupied
//   empty     no entries
//   head      oldest entry; only meaningful when !empty (no bypass)
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2   // power of 2, >= 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t wdata,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of 2.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs as they were before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/empty gate every read,
    // so stale contents are never observed and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register file's single write port between the ALU (single-cycle,
// high priority) and the mul/div unit (results buffered in wb_fifo). A wait
// counter forces the FIFO head through after it has lost MAX_WAIT cycles.
// Data/address widths come from wb_arb_pkg.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   AluValid/AluRd/AluData   ALU writeback request
//   AluReady                 ALU request accepted this cycle (comb.)
//   MulValid/MulRd/MulData   mul/div result offered to the FIFO
//   MulReady                 FIFO can accept this cycle (comb.)
//   RegWrite/rd/WriteData    registered register-file write port
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,  // power of 2, >= 2
    parameter int MAX_WAIT   = 4   // >= 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  AluValid,
    input  logic [REG_ADDR_W-1:0] AluRd,
    input  logic [XLEN-1:0]       AluData,
    output logic                  AluReady,
    input  logic                  MulValid,
    input  logic [REG_ADDR_W-1:0] MulRd,
    input  logic [XLEN-1:0]       MulData,
    output logic                  MulReady,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       WriteData
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic              fifo_full;
    logic              fifo_empty;
    wb_req_t           fifo_head;
    logic              head_valid;
    logic              force_head;
    logic [WAIT_W-1:0] wait_cnt;
    grant_t            grant;
    wb_req_t           sel_req;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (MulValid && MulReady),
        .wdata ('{rd: MulRd, data: MulData}),
        .pop   (grant == GNT_MUL),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign head_valid = !fifo_empty;
    assign force_head = head_valid && (wait_cnt == WAIT_W'(MAX_WAIT));

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant    = GNT_NONE;
        sel_req  = fifo_head;
        AluReady = !rst && !force_head;
        MulReady = !rst && !fifo_full;   // full blocks push even if popping
        if (!rst) begin
            if (force_head) begin
                grant = GNT_MUL;
            end else if (AluValid) begin
                grant   = GNT_ALU;
                sel_req = '{rd: AluRd, data: AluData};
            end else if (head_valid) begin
                grant = GNT_MUL;
            end
        end
    end

    // Counts cycles the FIFO head has been passed over; saturates at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (rst || fifo_empty || grant == GNT_MUL) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Write port: one-cycle latency from grant. A grant to x0 still completes
    // its handshake but never asserts RegWrite. Idle cycles hold rd/WriteData.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite  <= 1'b0;
            rd        <= '0;
            WriteData <= '0;
        end else if (grant == GNT_NONE) begin
            RegWrite  <= 1'b0;
        end else begin
            RegWrite  <= (sel_req.rd != '0);
            rd        <= sel_req.rd;
            WriteData <= sel_req.data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus pushes the expected write
// (rd, data, cycle it must appear) into a queue; a negedge monitor pops and
// compares every RegWrite pulse and flags missing or unexpected writes.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        AluValid;
    logic [4:0]  AluRd;
    logic [31:0] AluData;
    logic        AluReady;
    logic        MulValid;
    logic [4:0]  MulRd;
    logic [31:0] MulData;
    logic        MulReady;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] WriteData;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    wb_port_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .AluValid  (AluValid),
        .AluRd     (AluRd),
        .AluData   (AluData),
        .AluReady  (AluReady),
        .MulValid  (MulValid),
        .MulRd     (MulRd),
        .MulData   (MulData),
        .MulReady  (MulReady),
        .RegWrite  (RegWrite),
        .rd        (rd),
        .WriteData (WriteData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input int at, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.cyc  = at;
        e.rd   = r;
        e.data = d;
        expq.push_back(e);
    endtask

    // Monitor: every write must match the queue head, in order and on time.
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: rd=%0d data=%0h due cycle %0d not seen by %0d",
                     expq[0].rd, expq[0].data, expq[0].cyc, cyc);
            void'(expq.pop_front());
        end
        if (RegWrite === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: rd=%0d data=%0h at cycle %0d, none expected",
                         rd, WriteData, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("write_cycle", 64'(cyc), 64'(e.cyc));
                check("write_rd", 64'(rd), 64'(e.rd));
                check("write_data", 64'(WriteData), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; AluValid = 1'b0; AluRd = '0; AluData = '0;
        MulValid = 1'b0; MulRd = '0; MulData = '0;

        // Reset state
        repeat (2) step();
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_wdata", 64'(WriteData), 64'd0);
        check("rst_alu_ready", 64'(AluReady), 64'd0);
        check("rst_mul_ready", 64'(MulReady), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_alu_ready", 64'(AluReady), 64'd1);
        check("post_rst_mul_ready", 64'(MulReady), 64'd1);

        // 1. ALU only
        step();
        AluValid = 1'b1; AluRd = 5'd5; AluData = 32'd123;
        #1;
        check("t1_alu_ready", 64'(AluReady), 64'd1);
        expect_write(cyc + 1, 5'd5, 32'd123);
        step();
        check("t1_alu_ready_hold", 64'(AluReady), 64'd1);
        AluValid = 1'b0;
        step();

        // 2. Mul only: visible two cycles after the transfer cycle is set up
        MulValid = 1'b1; MulRd = 5'd7; MulData = 32'hDEAD;
        #1;
        check("t2_mul_ready", 64'(MulReady), 64'd1);
        expect_write(cyc + 2, 5'd7, 32'hDEAD);
        step();
        MulValid = 1'b0;
        repeat (3) step();

        // 3. Starvation: head rd=9 loses 4 cycles to the ALU, then is forced
        MulValid = 1'b1; MulRd = 5'd9; MulData = 32'h55;
        expect_write(cyc + 2 + 4, 5'd9, 32'h55);  // real entry queued after the ALU wins
        void'(expq.pop_back());
        step();
        MulValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            AluValid = 1'b1; AluRd = 5'd3; AluData = 32'(100 + i);
            #1;
            check("t3_alu_wins", 64'(AluReady), 64'd1);
            expect_write(cyc + 1, 5'd3, 32'(100 + i));
            step();
        end
        AluData = 32'd200;
        #1;
        check("t3_force_blocks_alu", 64'(AluReady), 64'd0);
        expect_write(cyc + 1, 5'd9, 32'h55);
        step();
        #1;
        check("t3_alu_resumes", 64'(AluReady), 64'd1);
        expect_write(cyc + 1, 5'd3, 32'd200);
        step();
        AluValid = 1'b0;
        repeat (2) step();

        // 4. Full FIFO while the ALU holds the port
        for (int i = 0; i < 3; i++) begin
            AluValid = 1'b1; AluRd = 5'd2; AluData = 32'(32'h300 + i);
            MulValid = 1'b1; MulRd = 5'(10 + i); MulData = 32'(32'hA0 + i);
            #1;
            if (i == 1) check("t4_mul_ready_one", 64'(MulReady), 64'd1);
            if (i == 2) check("t4_mul_ready_full", 64'(MulReady), 64'd0);
            expect_write(cyc + 1, 5'd2, 32'(32'h300 + i));
            step();
        end
        AluValid = 1'b0; MulValid = 1'b0;
        expect_write(cyc + 1, 5'd10, 32'hA0);
        expect_write(cyc + 2, 5'd11, 32'hA1);
        repeat (4) step();

        // 5. x0 write suppressed but accepted
        AluValid = 1'b1; AluRd = 5'd0; AluData = 32'hFFFF;
        #1;
        check("t5_alu_ready", 64'(AluReady), 64'd1);
        step();
        AluValid = 1'b0;
        check("t5_no_regwrite", 64'(RegWrite), 64'd0);
        step();

        // 6. Reset with two FIFO entries queued behind the ALU
        AluValid = 1'b1; AluRd = 5'd4; AluData = 32'h400;
        MulValid = 1'b1; MulRd = 5'd13; MulData = 32'hD0;
        expect_write(cyc + 1, 5'd4, 32'h400);
        step();
        AluData = 32'h401;
        MulRd = 5'd14; MulData = 32'hE0;
        expect_write(cyc + 1, 5'd4, 32'h401);
        step();
        MulValid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_alu_ready", 64'(AluReady), 64'd0);
        check("t6_rst_mul_ready", 64'(MulReady), 64'd0);
        step();
        check("t6_rst_regwrite", 64'(RegWrite), 64'd0);
        check("t6_rst_rd", 64'(rd), 64'd0);
        check("t6_rst_wdata", 64'(WriteData), 64'd0);
        rst = 1'b0; AluValid = 1'b0;
        #1;
        check("t6_mul_ready_after", 64'(MulReady), 64'd1);
        repeat (8) step();

        check("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
